alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU.
- Accepts one operation per valid/ready handshake and returns a registered result, compare flag and carry/borrow flag.
- Single-cycle ops complete in 1 cycle; multiply is iterative over WIDTH cycles.
- Sits between the register-file read stage and the writeback/branch-resolve stage of the processor.

Parameters:
- WIDTH, 16: operand and result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1: multiply iteration counter width (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request.
- op  in  4  0 add, 1 sub, 2 and, 3 or, 4 cmp, 5 parity, 6 mul; 7-15 reserved.
- cmp_mode  in  3  cmp only: 0 eq, 1 ne, 2 lt, 3 le, 4 gt, 5 ge (unsigned); 6-7 give 0.
- res  in  WIDTH  operand A.
- register  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- compres  out  1  compare result (updated by cmp only).
- carry  out  1  add carry-out / sub borrow (updated by add/sub only).

Behaviour:
- Reset values: in_ready=1, out_valid=0, out=0, compres=0, carry=0, state=IDLE, counter=0.
- Reset is asynchronous and aborts any operation in flight, including a mid-multiply. No partial result is ever presented.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, operands, op and cmp_mode are latched.
  - Non-mul op: result is computed and registered the same edge; go to DONE, out_valid=1 on the next cycle (latency 1).
  - mul: go to MUL with counter=0, accumulator=0, multiplicand=res, multiplier=register.
- MUL:
  - in_ready=0.
  - Each cycle: if multiplier LSB=1, accumulator += multiplicand (truncated to WIDTH). Then multiplicand <<1, multiplier >>1, counter+1.
  - After WIDTH iterations, out=accumulator (low WIDTH bits of product) and go to DONE.
  - Total latency from accept to out_valid: WIDTH+1 cycles.
- DONE:
  - out_valid=1, in_ready=0.
  - out, compres and carry are held stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE. A new request is accepted no earlier than the following cycle (no same-cycle turnaround).
- Arithmetic:
  - add: {carry,out} = res+register.
  - sub: out = res-register mod 2^WIDTH; carry=1 when res<register.
  - and / or: bitwise; carry and compres keep their previous values.
  - cmp: compres per cmp_mode; out = {WIDTH-1 zeros, compres}.
  - parity: out = {zeros, ^res} (odd-count bit); register is ignored.
  - Reserved ops: out=0, flags unchanged, latency 1.
- in_valid while in_ready=0 is ignored; the request must be held by the producer.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- ALU_SEQ_MUL_EN defined: op 6 behaves as the iterative multiplier above.
- Not defined: MUL state and its datapath are removed; op 6 is treated as reserved (out=0, latency 1).

Decomposition:
- Shared package alu_pkg holds:
  - op encoding localparams (OP_ADD..OP_MUL);
  - cmp_mode localparams;
  - state enum (IDLE, MUL, DONE).
- One natural sub-module: alu_seq_mul, the shift-add iterator. It has start/busy/done and WIDTH as parameter, and is instantiated only under ALU_SEQ_MUL_EN.

Test Plan (all at WIDTH=16):
- Reset asserted mid-cycle -> out_valid=0, in_ready=1, out=0 immediately, without waiting for a clock edge.
- add res=16'hFFFF, register=16'h0002 -> out=16'h0001, carry=1, out_valid exactly 1 cycle after accept. Then sub 16'h0003-16'h0005 -> out=16'hFFFE, carry=1.
- cmp_mode lt, res=5, register=9 -> compres=1, out=1. Then cmp_mode ge, same operands -> compres=0. A following and/or op leaves compres unchanged.
- parity res=16'h0007 -> out=1; res=16'h0003 -> out=0.
- mul 300*300 with ALU_SEQ_MUL_EN -> out=16'h5F90 (90000 mod 65536) after 17 cycles; in_ready=0 throughout; in_valid pulses during MUL are ignored. Without the macro -> out=0 after 1 cycle.
- out_ready held low 5 cycles in DONE -> out and flags stable, out_valid stays 1. Reset asserted at mul iteration 8 -> returns to IDLE; a subsequent add completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, compare modes and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_CMP    = 4'd4;
    localparam logic [3:0] OP_PARITY = 4'd5;
    localparam logic [3:0] OP_MUL    = 4'd6;

    // Unsigned comparisons; modes 6 and 7 always yield 0.
    localparam logic [2:0] CMP_EQ = 3'd0;
    localparam logic [2:0] CMP_NE = 3'd1;
    localparam logic [2:0] CMP_LT = 3'd2;
    localparam logic [2:0] CMP_LE = 3'd3;
    localparam logic [2:0] CMP_GT = 3'd4;
    localparam logic [2:0] CMP_GE = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: one partial product per cycle, WIDTH iterations, low WIDTH bits kept.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             w_last;

    // Done is presented for the one cycle after the final iteration.
    assign w_last = r_busy && (r_cnt == CNT_W'(WIDTH));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
        end else if (w_last) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = w_last;
    assign o_product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Registered valid/ready ALU. Define ALU_SEQ_MUL_EN to enable the iterative multiplier on op 6;
// otherwise op 6 is treated as a reserved opcode.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [2:0]       cmp_mode,
    input  logic [WIDTH-1:0] res,
    input  logic [WIDTH-1:0] register,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             compres,
    output logic             carry
);

    state_e           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_compres;
    logic             r_carry;

    logic [WIDTH-1:0] w_next_out;
    logic             w_next_compres;
    logic             w_next_carry;
    logic             w_cmp;
    logic [WIDTH:0]   w_sum;
    logic             w_is_mul;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

`ifdef ALU_SEQ_MUL_EN
    logic w_mul_start;

    assign w_is_mul    = (op == OP_MUL);
    assign w_mul_start = (r_state == IDLE) && in_valid && w_is_mul;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_start   (w_mul_start),
        .i_a       (res),
        .i_b       (register),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
`else
    assign w_is_mul      = 1'b0;
    assign w_mul_busy    = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
`endif

    assign w_sum = {1'b0, res} + {1'b0, register};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_out     = '0;
        w_next_compres = r_compres;
        w_next_carry   = r_carry;
        case (cmp_mode)
            CMP_EQ:  w_cmp = (res == register);
            CMP_NE:  w_cmp = (res != register);
            CMP_LT:  w_cmp = (res <  register);
            CMP_LE:  w_cmp = (res <= register);
            CMP_GT:  w_cmp = (res >  register);
            CMP_GE:  w_cmp = (res >= register);
            default: w_cmp = 1'b0;
        endcase
        case (op)
            OP_ADD: begin
                w_next_out   = w_sum[WIDTH-1:0];
                w_next_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_next_out   = res - register;
                w_next_carry = (res < register);
            end
            OP_AND:    w_next_out = res & register;
            OP_OR:     w_next_out = res | register;
            OP_CMP: begin
                w_next_out     = {{(WIDTH-1){1'b0}}, w_cmp};
                w_next_compres = w_cmp;
            end
            OP_PARITY: w_next_out = {{(WIDTH-1){1'b0}}, ^res};
            default:   w_next_out = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_compres   <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_is_mul) begin
                            r_state <= MUL;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_out       <= w_next_out;
                            r_compres   <= w_next_compres;
                            r_carry     <= w_next_carry;
                        end
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out       <= w_mul_product;
                    end else if (!w_mul_busy) begin
                        // Iterator lost its operation: never present a partial result.
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign compres   = r_compres;
    assign carry     = r_carry;

endmodule
